// File: rtl/addsub_pkg.sv
// Shared constants for the byte-serial add/sub unit: default width, byte width
// and the FSM state encoding.
package addsub_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W     = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage : addsub_pkg

// File: rtl/addsub_serial_unit_add8.sv
// Combinational 8-bit adder with carry-in; the single arithmetic element
// reused for every byte step.
module add8_cin (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] sum9;

  assign sum9 = 9'(a) + 9'(b) + 9'(cin);
  assign s    = sum9[7:0];
  assign cout = sum9[8];

endmodule : add8_cin

// File: rtl/addsub_serial_unit.sv
// Byte-serial add/subtract: latches A and B (pre-inverted for subtract), ripples
// one byte per cycle through add8_cin with a registered carry, then holds the result.
module addsub_serial_unit
  import addsub_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  localparam int N_BYTES = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_zero,
  output logic              busy
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [DATA_W-1:0] LOW_MASK = {DATA_W{1'b1}} >> BYTE_W;

  logic [1:0]        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              carry_reg;
  logic [DATA_W-1:0] s_reg;
  logic              out_valid_reg;
  logic              out_carry_reg;
  logic              out_ovf_reg;
  logic              out_zero_reg;

  logic [7:0] a_bytes [N_BYTES];
  logic [7:0] b_bytes [N_BYTES];
  logic [7:0] a_byte, b_byte, sum8;
  logic       cout8;
  logic       last_step;

  // Byte lanes of the latched operands, muxed by the step index.
  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lanes
      assign a_bytes[gi] = a_reg[gi*BYTE_W +: BYTE_W];
      assign b_bytes[gi] = b_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign a_byte    = a_bytes[idx_reg];
  assign b_byte    = b_bytes[idx_reg];
  assign last_step = (idx_reg == LAST_IDX);

  add8_cin u_add8 (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry_reg),
    .s    (sum8),
    .cout (cout8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
  end

  // Datapath: operand capture, byte ripple, flag capture and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      s_reg         <= '0;
      out_valid_reg <= 1'b0;
      out_carry_reg <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b ^ {DATA_W{in_sub}};
            carry_reg <= in_sub;
            idx_reg   <= '0;
          end
        end
        CALC: begin
          s_reg[idx_reg*BYTE_W +: BYTE_W] <= sum8;
          carry_reg <= cout8;
          idx_reg   <= idx_reg + 1'b1;
          if (last_step) begin
            out_valid_reg <= 1'b1;
            out_carry_reg <= cout8;
            out_ovf_reg   <= (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                             (sum8[7] != a_reg[DATA_W-1]);
            // Lower bytes are already final; top byte is still in flight.
            out_zero_reg  <= ((s_reg & LOW_MASK) == '0) && (sum8 == 8'd0);
          end
        end
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_s     = s_reg;
  assign out_carry = out_carry_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_zero  = out_zero_reg;

endmodule : addsub_serial_unit

// File: tb/tb_addsub_serial_unit.sv
// Directed bench for addsub_serial_unit: vector table for arithmetic, plus
// hand-written backpressure and mid-operation reset sequences.
module tb_addsub_serial_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_s;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_s;
    logic        exp_c;
    logic        exp_ovf;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [10];

  addsub_serial_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Accept at E0, count edges to out_valid, check result, consume it.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " out_s"}, out_s, v.exp_s);
    chk({tag, " carry"}, 32'(out_carry), 32'(v.exp_c));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    chk({tag, " zero"}, 32'(out_zero), 32'(v.exp_zero));
    $display("op %s: a=0x%08h b=0x%08h sub=%0d -> s=0x%08h c=%0d ovf=%0d z=%0d lat=%0d",
             tag, v.a, v.b, v.sub, out_s, out_carry, out_ovf, out_zero, lat);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_s"}, out_s, 32'd0);
    chk({tag, " out_carry"}, 32'(out_carry), 32'd0);
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'd0);
    chk({tag, " out_zero"}, 32'(out_zero), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    //            a             b             sub   s             c     ovf   z
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h7777_7788, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-release in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold the result for 5 cycles while a new request is offered.
    v = '{32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_sub = v.sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1111_1111; in_sub = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d out_s", k), out_s, 32'd30);
      chk($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp hold%0d busy", k), 32'(busy), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp in_ready after take", 32'(in_ready), 32'd1);
    chk("bp out_valid after take", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("bp ignored request not queued", 32'(busy), 32'd0);
    $display("op backpressure: s=0x%08h held 5 cycles", 32'd30);

    // Reset after E2 of an operation.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midcalc reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midcalc post-release in_ready", 32'(in_ready), 32'd1);
    $display("op midcalc reset: outputs cleared");
    run_op('{32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0}, "after-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule : tb_addsub_serial_unit
